// File: rtl/pc_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_branch_unit
//  Description : Program counter and branch/jump resolution stage. Holds the
//                PC, performs sequential increments, resolves conditional
//                branches against the registered CON flag and executes
//                register jumps with an optional link value for R15.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_branch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               OFF_BITS = 19
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      ir,
    input  logic             con_in,
    input  logic             pc_inc,
    input  logic             br_start,
    input  logic             jump_start,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             link_en,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] link_value,
    output logic             link_we,
    output logic             busy,
    output logic             done,
    output logic             taken
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_CON = 3'd1,
        S_CALC     = 3'd2,
        S_COMMIT   = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_offset;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_link_value;
    logic             r_link_flag;
    logic             r_taken;
    logic [WIDTH-1:0] w_offset_sext;

    // Only the offset field of the instruction is consumed here.
    logic w_unused_ir;
    assign w_unused_ir = &{1'b0, ir[31:OFF_BITS]};

    // Two's-complement sign extension of the branch offset field.
    assign w_offset_sext = {{(WIDTH-OFF_BITS){ir[OFF_BITS-1]}}, ir[OFF_BITS-1:0]};

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: branch beats jump beats increment in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (br_start) begin
                    w_state_next = S_WAIT_CON;
                end else if (jump_start) begin
                    w_state_next = S_COMMIT;
                end
            end
            S_WAIT_CON: w_state_next = con_in ? S_CALC : S_DONE;
            S_CALC:     w_state_next = S_COMMIT;
            S_COMMIT:   w_state_next = S_DONE;
            S_DONE:     w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // Datapath: PC, latched offset, resolved target, link value and result flag.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_pc         <= RESET_PC;
            r_offset     <= '0;
            r_target     <= '0;
            r_link_value <= '0;
            r_link_flag  <= 1'b0;
            r_taken      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (br_start) begin
                        // Offset is captured now so later ir changes are harmless.
                        r_offset    <= w_offset_sext;
                        r_link_flag <= 1'b0;
                    end else if (jump_start) begin
                        r_target     <= jump_target;
                        r_link_value <= r_pc;
                        r_link_flag  <= link_en;
                        r_taken      <= 1'b1;
                    end else if (pc_inc) begin
                        r_pc <= r_pc + c_one;
                    end
                end
                S_WAIT_CON: begin
                    // CON is registered upstream on the br_start edge, so it
                    // is only valid one cycle later.
                    r_taken <= con_in;
                end
                S_CALC: begin
                    r_target <= r_pc + r_offset;
                end
                S_COMMIT: begin
                    r_pc <= r_target;
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs decoded directly from the state.
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign link_we    = (r_state == S_COMMIT) && r_link_flag;
    assign pc_out     = r_pc;
    assign link_value = r_link_value;
    assign taken      = r_taken;

endmodule
`default_nettype wire

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
Program-counter and branch-resolution stage sitting directly downstream of the CON flip-flop logic. It holds the PC, applies sequential increments, and resolves conditional branches. For conditional branches it samples the registered CON flag and adds the sign-extended 19-bit offset. It also executes register jumps (jr/jal) with an optional link value for R15. A small FSM sequences the multi-cycle update and reports completion to the control unit.

Parameters:
WIDTH, 32, PC/data width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
OFF_BITS, 19, branch offset field width (ir[18:0]), sign bit at ir[OFF_BITS-1]

Ports:
clk  in  1  system clock, all state updates on rising edge
clr  in  1  asynchronous active-low reset
ir  in  32  instruction register contents; offset taken from ir[18:0]
con_in  in  1  registered CON flag from the control-flow logic
pc_inc  in  1  request PC <= PC+1 (fetch); honoured only in IDLE
br_start  in  1  one-cycle pulse: begin conditional branch resolution
jump_start  in  1  one-cycle pulse: begin register jump
jump_target  in  32  jump destination (Ra value from bus), sampled with jump_start
link_en  in  1  jal: produce link value, sampled with jump_start
pc_out  out  32  current PC
link_value  out  32  PC captured at jump_start (return address)
link_we  out  1  one-cycle write strobe for link_value into R15
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
taken  out  1  result of last branch/jump (1 = PC redirected)

Behaviour:
- Reset (clr=0, async, any state): state=IDLE; pc_out=RESET_PC; link_value=0; link_we=0; busy=0; done=0; taken=0; internal target and ir-offset registers cleared. Reset mid-operation aborts with no PC update.
- States: IDLE, WAIT_CON, CALC, COMMIT, DONE.
- IDLE priority per edge: br_start > jump_start > pc_inc. A lower-priority request in the same cycle is dropped.
- IDLE, pc_inc=1 only: pc <= pc+1 modulo 2^32 (32'hFFFF_FFFF -> 0). No done pulse.
- br_start (edge E0): latch offset = sign-extend(ir[18:0]) to 32 bits; -> WAIT_CON. The ir may change afterwards without effect.
- WAIT_CON (edge E1): taken <= con_in. If con_in=1, -> CALC; otherwise -> DONE with PC unchanged.
  - This one-cycle wait exists because CON is registered upstream on the same edge br_start is issued.
- CALC (E2): target <= pc + offset, modulo 2^32; -> COMMIT.
- COMMIT (E3): pc <= target; link_we=1 during this state only if the op is a jump with link_en latched; -> DONE.
- DONE: done=1 for exactly one cycle; -> IDLE on next edge.
- Latency from the edge sampling br_start to done high: taken = 4 cycles (done during cycle after E3); not-taken = 2 cycles.
- jump_start (E0): target <= jump_target; link_value <= current pc; link flag <= link_en; taken <= 1; -> COMMIT. Done follows 2 cycles after E0.
- While busy: pc_inc, br_start and jump_start are ignored (no queuing); con_in is ignored outside WAIT_CON.
- link_value holds until the next jump_start or reset. taken holds until the next br_start/jump_start resolves.
- Offset arithmetic: offset is two's complement with range -262144..+262143. The PC base is the already-incremented PC held at E2.

Test Plan:
- Reset: drive clr=0 mid-CALC -> pc_out=0, busy=0, done=0, taken=0 immediately without waiting for clk; after release, pc_inc x3 -> pc_out=3.
- Taken branch: pc=0x10, ir[18:0]=0x00005, con_in=1 at E1 -> pc_out=0x15 after E3, done pulse one cycle later, taken=1, link_we never high.
- Negative offset/not taken: pc=0x10, ir[18:0]=0x7FFFC (-4), con_in=1 -> pc=0x0C. Repeat with con_in=0 -> pc stays 0x0C, done 2 cycles after br_start, taken=0.
- Wrap: pc=0xFFFF_FFFE, offset +3, taken -> pc=0x0000_0001. Separately, pc_inc at 0xFFFF_FFFF -> 0.
- jal: pc=0x20, jump_start with jump_target=0x400 and link_en=1 -> link_value=0x20, link_we high one cycle in COMMIT, pc=0x400, done 2 cycles after start.
- Collisions: br_start+jump_start+pc_inc in the same cycle -> branch only, PC not incremented. pc_inc and br_start pulsed while busy -> ignored, PC matches branch result only.
